// File: rtl/dma_pkg.sv
// dma_pkg: shared types for the DMA descriptor path.
//   t_dma_cmd             - command to a read or write master {addr, length}
//   t_dma_desc            - descriptor as written by the CSR block
//   t_dispatch_state      - dispatcher FSM states
//   t_dma_dispatch_status - status bits laid out for direct CSR readback
// The struct widths follow the default address/length widths of the DMA.
package dma_pkg;

    localparam int DMA_ADDR_W = 64;
    localparam int DMA_LEN_W  = 32;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_LEN_W-1:0]  length;
    } t_dma_cmd;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src_addr;
        logic [DMA_ADDR_W-1:0] dest_addr;
        logic [DMA_LEN_W-1:0]  length;
    } t_dma_desc;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } t_dispatch_state;

    typedef struct packed {
        logic busy;
        logic empty;
        logic full;
        logic stopped;
        logic overflow;
    } t_dma_dispatch_status;

endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: synchronous register FIFO for DMA descriptors.
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate counter; fill_level is the pointer difference.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   flush         - synchronous pointer clear, same effect as reset
//   push, push_data - write strobe/data (ignored when full)
//   pop, pop_data   - read strobe (ignored when empty) / head entry
//   empty, full, fill_level - occupancy
module dma_desc_fifo #(
    parameter int W     = 160,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   fill_level
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill_level = wr_ptr - rd_ptr;
    assign pop_data   = mem[rd_ptr[AW-1:0]];

    // full/empty are from the registered pointers, so a pop in the same
    // cycle never makes room for a push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage has no reset; only entries between the pointers are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dma_dispatcher.sv
// dma_dispatcher: queues descriptors from the CSR block and issues each as a
// read command plus a write command, waiting for both masters to finish
// before starting the next one.
// Handshake: a command transfers on a rising clk edge where valid && ready;
// once valid is high it stays high with a stable payload until that edge
// (only reset or ctrl_reset_dispatcher withdraws it).
// Ports:
//   clk, reset_n                         - clock, synchronous active-low reset
//   desc_src_addr/dest_addr/length, desc_go - descriptor push
//   ctrl_stop                            - hold off new descriptors
//   ctrl_reset_dispatcher                - synchronous flush
//   rd_cmd_*, wr_cmd_*                   - command channels to the masters
//   rd_done, wr_done                     - master completion pulses
//   status_*, fill_level, seq_num        - CSR readback
//   dbg_state                            - current FSM state
module dma_dispatcher
    import dma_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 32,
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        desc_src_addr,
    input  logic [ADDR_W-1:0]        desc_dest_addr,
    input  logic [LEN_W-1:0]         desc_length,
    input  logic                     desc_go,
    input  logic                     ctrl_stop,
    input  logic                     ctrl_reset_dispatcher,
    output logic                     rd_cmd_valid,
    input  logic                     rd_cmd_ready,
    output logic [ADDR_W-1:0]        rd_cmd_addr,
    output logic [LEN_W-1:0]         rd_cmd_length,
    output logic                     wr_cmd_valid,
    input  logic                     wr_cmd_ready,
    output logic [ADDR_W-1:0]        wr_cmd_addr,
    output logic [LEN_W-1:0]         wr_cmd_length,
    input  logic                     rd_done,
    input  logic                     wr_done,
    output logic                     status_busy,
    output logic                     status_empty,
    output logic                     status_full,
    output logic                     status_stopped,
    output logic                     status_overflow,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [SEQ_W-1:0]         seq_num,
    output t_dispatch_state          dbg_state
);

    localparam int DESC_W = 2*ADDR_W + LEN_W;

    t_dispatch_state      state_q, state_d;
    t_dma_dispatch_status status;

    logic [DESC_W-1:0] head;
    logic [ADDR_W-1:0] head_src;
    logic [ADDR_W-1:0] head_dest;
    logic [LEN_W-1:0]  head_len;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              complete;
    logic              rd_valid_d, wr_valid_d;
    logic              rd_flag_q, rd_flag_d;
    logic              wr_flag_q, wr_flag_d;
    logic              overflow_q;

    assign {head_src, head_dest, head_len} = head;

    dma_desc_fifo #(
        .W     (DESC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (ctrl_reset_dispatcher),
        .push       (desc_go && !ctrl_reset_dispatcher),
        .push_data  ({desc_src_addr, desc_dest_addr, desc_length}),
        .pop        (pop && !ctrl_reset_dispatcher),
        .pop_data   (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .fill_level (fill_level)
    );

    // Next-state and datapath controls.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        complete   = 1'b0;
        rd_valid_d = rd_cmd_valid;
        wr_valid_d = wr_cmd_valid;
        rd_flag_d  = rd_flag_q;
        wr_flag_d  = wr_flag_q;
        case (state_q)
            IDLE: begin
                // Done pulses outside a transfer are stale; drop them.
                rd_flag_d = 1'b0;
                wr_flag_d = 1'b0;
                if (!fifo_empty && !ctrl_stop) begin
                    pop = 1'b1;
                    if (head_len != '0) begin
                        state_d    = ISSUE;
                        rd_valid_d = 1'b1;
                        wr_valid_d = 1'b1;
                    end else begin
                        // Nothing to move: retire immediately.
                        complete = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // A done can arrive right after its own handshake while the
                // other command is still pending, so latch from here on.
                rd_flag_d = rd_flag_q | rd_done;
                wr_flag_d = wr_flag_q | wr_done;
                if (rd_cmd_valid && rd_cmd_ready) rd_valid_d = 1'b0;
                if (wr_cmd_valid && wr_cmd_ready) wr_valid_d = 1'b0;
                if (!rd_valid_d && !wr_valid_d) state_d = WAIT;
            end
            WAIT: begin
                if (rd_flag_q && wr_flag_q) begin
                    state_d   = IDLE;
                    complete  = 1'b1;
                    rd_flag_d = 1'b0;
                    wr_flag_d = 1'b0;
                end else begin
                    rd_flag_d = rd_flag_q | rd_done;
                    wr_flag_d = wr_flag_q | wr_done;
                end
            end
            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
                wr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rd_cmd_valid  <= 1'b0;
            wr_cmd_valid  <= 1'b0;
            rd_flag_q     <= 1'b0;
            wr_flag_q     <= 1'b0;
            overflow_q    <= 1'b0;
            seq_num       <= '0;
            rd_cmd_addr   <= '0;
            rd_cmd_length <= '0;
            wr_cmd_addr   <= '0;
            wr_cmd_length <= '0;
        end else if (ctrl_reset_dispatcher) begin
            // Flush wins over push, pop and completion. Payload registers
            // are left alone; with valids low they carry no meaning.
            state_q      <= IDLE;
            rd_cmd_valid <= 1'b0;
            wr_cmd_valid <= 1'b0;
            rd_flag_q    <= 1'b0;
            wr_flag_q    <= 1'b0;
            overflow_q   <= 1'b0;
            seq_num      <= '0;
        end else begin
            state_q      <= state_d;
            rd_cmd_valid <= rd_valid_d;
            wr_cmd_valid <= wr_valid_d;
            rd_flag_q    <= rd_flag_d;
            wr_flag_q    <= wr_flag_d;
            if (desc_go && fifo_full) overflow_q <= 1'b1;
            if (complete) seq_num <= seq_num + SEQ_W'(1);
            if (pop) begin
                rd_cmd_addr   <= head_src;
                rd_cmd_length <= head_len;
                wr_cmd_addr   <= head_dest;
                wr_cmd_length <= head_len;
            end
        end
    end

    always_comb begin
        status.busy     = (state_q != IDLE);
        status.empty    = fifo_empty;
        status.full     = fifo_full;
        status.stopped  = ctrl_stop && (state_q == IDLE);
        status.overflow = overflow_q;
    end

    assign status_busy     = status.busy;
    assign status_empty    = status.empty;
    assign status_full     = status.full;
    assign status_stopped  = status.stopped;
    assign status_overflow = status.overflow;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_dma_dispatcher.sv
// tb_dma_dispatcher: directed bench for dma_dispatcher. Stimulus pushes the
// expected read/write commands into queues; a monitor on the falling edge
// compares every presented command against the queue heads and also plays
// the masters' done pulses with a programmable delay.
module tb_dma_dispatcher;
    import dma_pkg::*;

    localparam int ADDR_W = 64;
    localparam int LEN_W  = 32;
    localparam int DEPTH  = 16;
    localparam int SEQ_W  = 16;
    localparam int FL_W   = $clog2(DEPTH) + 1;
    localparam int CMD_W  = ADDR_W + LEN_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] desc_src_addr = '0;
    logic [ADDR_W-1:0] desc_dest_addr = '0;
    logic [LEN_W-1:0]  desc_length = '0;
    logic              desc_go = 1'b0;
    logic              ctrl_stop = 1'b0;
    logic              ctrl_reset_dispatcher = 1'b0;
    logic              rd_cmd_valid, wr_cmd_valid;
    logic              rd_cmd_ready = 1'b1;
    logic              wr_cmd_ready = 1'b1;
    logic [ADDR_W-1:0] rd_cmd_addr, wr_cmd_addr;
    logic [LEN_W-1:0]  rd_cmd_length, wr_cmd_length;
    logic              rd_done = 1'b0;
    logic              wr_done = 1'b0;
    logic              status_busy, status_empty, status_full;
    logic              status_stopped, status_overflow;
    logic [FL_W-1:0]   fill_level;
    logic [SEQ_W-1:0]  seq_num;
    t_dispatch_state   dbg_state;

    dma_dispatcher #(
        .ADDR_W (ADDR_W), .LEN_W (LEN_W), .DEPTH (DEPTH), .SEQ_W (SEQ_W)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .desc_src_addr         (desc_src_addr),
        .desc_dest_addr        (desc_dest_addr),
        .desc_length           (desc_length),
        .desc_go               (desc_go),
        .ctrl_stop             (ctrl_stop),
        .ctrl_reset_dispatcher (ctrl_reset_dispatcher),
        .rd_cmd_valid          (rd_cmd_valid),
        .rd_cmd_ready          (rd_cmd_ready),
        .rd_cmd_addr           (rd_cmd_addr),
        .rd_cmd_length         (rd_cmd_length),
        .wr_cmd_valid          (wr_cmd_valid),
        .wr_cmd_ready          (wr_cmd_ready),
        .wr_cmd_addr           (wr_cmd_addr),
        .wr_cmd_length         (wr_cmd_length),
        .rd_done               (rd_done),
        .wr_done               (wr_done),
        .status_busy           (status_busy),
        .status_empty          (status_empty),
        .status_full           (status_full),
        .status_stopped        (status_stopped),
        .status_overflow       (status_overflow),
        .fill_level            (fill_level),
        .seq_num               (seq_num),
        .dbg_state             (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [CMD_W-1:0] exp_rd_q[$];
    logic [CMD_W-1:0] exp_wr_q[$];
    int total = 0;
    int bad = 0;
    int rd_hs = 0;
    int wr_hs = 0;
    int rd_done_dly = 1;
    int wr_done_dly = 1;
    int rd_cnt = 0;
    int wr_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor + master model ----------------
    always @(negedge clk) begin
        // Done pulses: set on the falling edge so the DUT sees them at the
        // end of cycle (handshake cycle + delay).
        rd_done = 1'b0;
        wr_done = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) rd_done = 1'b1;
        end
        if (wr_cnt > 0) begin
            wr_cnt--;
            if (wr_cnt == 0) wr_done = 1'b1;
        end
        if (reset_n && rd_cmd_valid) begin
            check("rd_cmd_expected", 128'(exp_rd_q.size() != 0), 128'(1));
            if (exp_rd_q.size() != 0) begin
                check("rd_cmd_payload", 128'({rd_cmd_addr, rd_cmd_length}), 128'(exp_rd_q[0]));
                if (rd_cmd_ready) begin
                    void'(exp_rd_q.pop_front());
                    rd_hs++;
                    rd_cnt = rd_done_dly;
                end
            end
        end
        if (reset_n && wr_cmd_valid) begin
            check("wr_cmd_expected", 128'(exp_wr_q.size() != 0), 128'(1));
            if (exp_wr_q.size() != 0) begin
                check("wr_cmd_payload", 128'({wr_cmd_addr, wr_cmd_length}), 128'(exp_wr_q[0]));
                if (wr_cmd_ready) begin
                    void'(exp_wr_q.pop_front());
                    wr_hs++;
                    wr_cnt = wr_done_dly;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_desc(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dest,
                             input logic [LEN_W-1:0] len, input bit will_issue);
        desc_src_addr  = src;
        desc_dest_addr = dest;
        desc_length    = len;
        desc_go        = 1'b1;
        if (will_issue && len != '0) begin
            exp_rd_q.push_back({src, len});
            exp_wr_q.push_back({dest, len});
        end
        tick();
        desc_go = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (!status_busy && status_empty) seen = 1'b1;
        end
        check(name, 128'(seen), 128'(1));
    endtask

    task automatic wait_rd_valid(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (rd_cmd_valid) seen = 1'b1;
        end
        check(name, 128'(seen), 128'(1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int busy_cycles;
        logic [SEQ_W-1:0] seq_before;
        int rd_before, wr_before;

        // Reset values, with stop both set and clear.
        reset_n   = 1'b0;
        ctrl_stop = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rd_valid", 128'(rd_cmd_valid), 128'(0));
        check("rst_wr_valid", 128'(wr_cmd_valid), 128'(0));
        check("rst_busy", 128'(status_busy), 128'(0));
        check("rst_empty", 128'(status_empty), 128'(1));
        check("rst_full", 128'(status_full), 128'(0));
        check("rst_stopped_set", 128'(status_stopped), 128'(1));
        check("rst_overflow", 128'(status_overflow), 128'(0));
        check("rst_fill", 128'(fill_level), 128'(0));
        check("rst_seq", 128'(seq_num), 128'(0));
        check("rst_rd_payload", 128'({rd_cmd_addr, rd_cmd_length}), 128'(0));
        check("rst_wr_payload", 128'({wr_cmd_addr, wr_cmd_length}), 128'(0));
        tick();
        ctrl_stop = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        check("rst_stopped_clr", 128'(status_stopped), 128'(0));
        tick();

        // Single descriptor, ready=1, done one cycle after handshake.
        push_desc(64'h1000, 64'h2000, 32'h40, 1'b1);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (status_busy) busy_cycles++;
        end
        check("t1_busy_cycles", 128'(busy_cycles), 128'(3));
        check("t1_seq", 128'(seq_num), 128'(1));
        check("t1_queues_drained", 128'(exp_rd_q.size() + exp_wr_q.size()), 128'(0));

        // Overfill while stopped, then release.
        tick();
        ctrl_stop = 1'b1;
        for (int i = 0; i <= DEPTH; i++)
            push_desc(64'h10000 + 64'(i) * 64'h100, 64'h80000 + 64'(i) * 64'h100,
                      32'h10 + 32'(i) * 32'h4, i < DEPTH);
        @(negedge clk);
        check("t2_fill", 128'(fill_level), 128'(DEPTH));
        check("t2_full", 128'(status_full), 128'(1));
        check("t2_overflow", 128'(status_overflow), 128'(1));
        check("t2_stopped", 128'(status_stopped), 128'(1));
        check("t2_busy", 128'(status_busy), 128'(0));
        tick();
        ctrl_stop = 1'b0;
        wait_idle("t2_drain", DEPTH * 8 + 20);
        check("t2_seq", 128'(seq_num), 128'(1 + DEPTH));
        check("t2_all_issued", 128'(exp_rd_q.size() + exp_wr_q.size()), 128'(0));
        check("t2_overflow_sticky", 128'(status_overflow), 128'(1));

        // Read ready held low for 5 cycles; write goes first.
        tick();
        rd_cmd_ready = 1'b0;
        push_desc(64'h3000, 64'h4000, 32'h20, 1'b1);
        wait_rd_valid("t3_rd_valid_seen", 10);
        for (int i = 0; i < 5; i++) begin
            check("t3_state_issue", 128'(dbg_state), 128'(ISSUE));
            check("t3_rd_valid_held", 128'(rd_cmd_valid), 128'(1));
            check("t3_wr_valid", 128'(wr_cmd_valid), 128'(i == 0));
            if (i < 4) @(negedge clk);
        end
        tick();
        rd_cmd_ready = 1'b1;
        @(negedge clk);
        check("t3_state_at_rd_hs", 128'(dbg_state), 128'(ISSUE));
        @(negedge clk);
        check("t3_state_wait", 128'(dbg_state), 128'(WAIT));
        check("t3_rd_valid_drop", 128'(rd_cmd_valid), 128'(0));
        wait_idle("t3_done", 20);
        check("t3_seq", 128'(seq_num), 128'(2 + DEPTH));

        // wr_done 10 cycles ahead of rd_done.
        tick();
        rd_done_dly = 11;
        wr_done_dly = 1;
        push_desc(64'h5000, 64'h6000, 32'h100, 1'b1);
        wait_rd_valid("t4_rd_valid_seen", 10);
        seq_before = seq_num;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            if (j <= 12) begin
                check("t4_seq_hold", 128'(seq_num), 128'(seq_before));
                check("t4_state_wait", 128'(dbg_state), 128'(WAIT));
            end else begin
                check("t4_seq_inc", 128'(seq_num), 128'(seq_before + SEQ_W'(1)));
                check("t4_state_idle", 128'(dbg_state), 128'(IDLE));
            end
        end
        rd_done_dly = 1;

        // Flush mid-ISSUE with 3 entries still queued.
        tick();
        rd_cmd_ready = 1'b0;
        wr_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_desc(64'hA000 + 64'(i), 64'hB000 + 64'(i), 32'h8, 1'b1);
        wait_rd_valid("t6_rd_valid_seen", 10);
        check("t6_fill_before", 128'(fill_level), 128'(3));
        check("t6_overflow_before", 128'(status_overflow), 128'(1));
        check("t6_state_before", 128'(dbg_state), 128'(ISSUE));
        tick();
        ctrl_reset_dispatcher = 1'b1;
        tick();
        ctrl_reset_dispatcher = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(negedge clk);
        check("t6_rd_valid", 128'(rd_cmd_valid), 128'(0));
        check("t6_wr_valid", 128'(wr_cmd_valid), 128'(0));
        check("t6_fill", 128'(fill_level), 128'(0));
        check("t6_seq", 128'(seq_num), 128'(0));
        check("t6_overflow", 128'(status_overflow), 128'(0));
        check("t6_empty", 128'(status_empty), 128'(1));
        check("t6_busy", 128'(status_busy), 128'(0));
        tick();
        rd_cmd_ready = 1'b1;
        wr_cmd_ready = 1'b1;

        // Zero-length descriptor between two 0x80 descriptors.
        rd_before = rd_hs;
        wr_before = wr_hs;
        push_desc(64'hC000, 64'hD000, 32'h80, 1'b1);
        push_desc(64'hC100, 64'hD100, 32'h0, 1'b1);
        push_desc(64'hC200, 64'hD200, 32'h80, 1'b1);
        wait_idle("t5_done", 40);
        check("t5_seq", 128'(seq_num), 128'(3));
        check("t5_rd_cmds", 128'(rd_hs - rd_before), 128'(2));
        check("t5_wr_cmds", 128'(wr_hs - wr_before), 128'(2));

        repeat (3) @(negedge clk);
        check("final_rd_q_empty", 128'(exp_rd_q.size()), 128'(0));
        check("final_wr_q_empty", 128'(exp_wr_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
